// File: rtl/comp_tree_pipe_if.sv
// comp_tree_pipe_if: valid/ready operand beat and redundant/full result bus for comp_tree_pipe
interface comp_tree_pipe_if #(
  parameter int SIZE = 8,
  parameter int NUM_IN = 8
);
  localparam int W = SIZE + $clog2(NUM_IN);
  logic in_valid, in_ready, approx_en, out_valid, out_ready, out_approx;
  logic [NUM_IN*SIZE-1:0] in_data;
  logic [W-1:0] out_sum, out_carry;
  modport master (
    output in_valid, in_data, approx_en, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_approx
  );
  modport slave (
    input  in_valid, in_data, approx_en, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_approx
  );
endinterface

// File: rtl/comp_tree_pipe.sv
// comp_tree_pipe: pipelined 4:2 carry-save compressor tree with valid/ready flow; `define COMP_TREE_CPA_EN adds a final carry-propagate stage
module comp_tree_pipe #(
  parameter int SIZE = 8,
  parameter int NUM_IN = 8,
  parameter int APPROX_BITS = 0
) (
  input logic clk,
  input logic rst_n,
  comp_tree_pipe_if.slave bus
);
  localparam int W = SIZE + $clog2(NUM_IN);
  localparam int L = $clog2(NUM_IN) - 1;
`ifdef COMP_TREE_CPA_EN
  localparam int S = L + 1;
`else
  localparam int S = L;
`endif
  localparam logic [SIZE-1:0] MASK = SIZE'((1 << APPROX_BITS) - 1);
  logic [S-1:0] r_vld, r_apx, w_adv, w_pv, w_pa;
  logic [W-1:0] w_cond [NUM_IN];
  function automatic logic [2*W-1:0] c42(input logic [W-1:0] a, b, c, d);
    logic [W-1:0] p, q, x, y;
    p = a ^ b ^ c;
    q = ((a & b) | (a & c) | (b & c)) << 1;
    x = p ^ q ^ d;
    y = ((p & q) | (p & d) | (q & d)) << 1;
    return {x, y};
  endfunction
  for (genvar k = 0; k < NUM_IN; k++) begin : cond
    logic [SIZE-1:0] w_op;
    assign w_op = bus.in_data[k*SIZE +: SIZE] & ~(bus.approx_en ? MASK : '0);
    assign w_cond[k] = {{(W-SIZE){w_op[SIZE-1]}}, w_op};
  end
  for (genvar k = 0; k < S; k++) begin : ctl
    assign w_adv[k] = bus.out_ready || !(&r_vld[S-1:k]);
    if (k == 0) begin : h
      assign w_pv[k] = bus.in_valid;
      assign w_pa[k] = bus.approx_en;
    end else begin : t
      assign w_pv[k] = r_vld[k-1];
      assign w_pa[k] = r_apx[k-1];
    end
  end
  assign bus.in_ready = w_adv[0];
  assign bus.out_valid = r_vld[S-1];
  assign bus.out_approx = r_apx[S-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_vld <= '0;
      r_apx <= '0;
    end else
      for (int s = 0; s < S; s++)
        if (w_adv[s]) begin
          r_vld[s] <= w_pv[s];
          if (w_pv[s]) r_apx[s] <= w_pa[s];
        end
  for (genvar g = 0; g < L; g++) begin : lv
    localparam int N = NUM_IN >> g;
    logic [W-1:0] w_in [N];
    logic [W-1:0] w_out [N/2];
    logic [W-1:0] r_v [N/2];
    if (g == 0) begin : h
      assign w_in = w_cond;
    end else begin : t
      assign w_in = lv[g-1].r_v;
    end
    for (genvar k = 0; k < N/4; k++) begin : cp
      assign {w_out[2*k], w_out[2*k+1]} = c42(w_in[4*k], w_in[4*k+1], w_in[4*k+2], w_in[4*k+3]);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
        for (int i = 0; i < N/2; i++) r_v[i] <= '0;
      else if (w_adv[g] && w_pv[g])
        r_v <= w_out;
  end
`ifdef COMP_TREE_CPA_EN
  logic [W-1:0] r_sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sum <= '0;
    else if (w_adv[L] && w_pv[L]) r_sum <= lv[L-1].r_v[0] + lv[L-1].r_v[1];
  assign bus.out_sum = r_sum;
  assign bus.out_carry = '0;
`else
  assign bus.out_sum = lv[L-1].r_v[0];
  assign bus.out_carry = lv[L-1].r_v[1];
`endif
endmodule

// File: tb/tb_comp_tree_pipe.sv
// tb_comp_tree_pipe: scoreboard bench for comp_tree_pipe, SIZE=8 NUM_IN=8 APPROX_BITS=2, either COMP_TREE_CPA_EN build
module tb_comp_tree_pipe;
  localparam int W = 11;
`ifdef COMP_TREE_CPA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    logic [W-1:0] sum;
    logic apx;
    int acc;
  } exp_t;
  logic clk = 0;
  logic rst_n = 1;
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int nacc = 0;
  bit chk_lat = 1;
  exp_t sb[$];
  exp_t mx;
  comp_tree_pipe_if #(.SIZE(8), .NUM_IN(8)) bus();
  comp_tree_pipe #(.SIZE(8), .NUM_IN(8), .APPROX_BITS(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask
  task automatic send(input logic [63:0] d, input logic a, input logic [W-1:0] e);
    int n;
    exp_t x;
    n = 0;
    bus.in_valid = 1;
    bus.in_data = d;
    bus.approx_en = a;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("accept_timeout", W'(bus.in_ready), 1);
    else begin
      x.sum = e;
      x.apx = a;
      x.acc = cyc + 1;
      sb.push_back(x);
      nacc++;
    end
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_left", W'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_beat: got sum %0h, expected no beat", bus.out_sum);
      end else begin
        mx = sb.pop_front();
        chk("sum", bus.out_sum + bus.out_carry, mx.sum);
        chk("approx_tag", W'(bus.out_approx), W'(mx.apx));
`ifdef COMP_TREE_CPA_EN
        chk("carry_zero", bus.out_carry, 0);
`endif
        if (chk_lat) chk("latency", W'(cyc - mx.acc), W'(LAT - 1));
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] s0, c0;
    logic a0;
    int n;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.approx_en = 0;
    bus.out_ready = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", W'(bus.out_valid), 0);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_out_carry", bus.out_carry, 0);
    chk("rst_out_approx", W'(bus.out_approx), 0);
    chk("rst_in_ready", W'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rel_in_ready", W'(bus.in_ready), 1);
    for (int k = 0; k < 8; k++) send({8{8'h01}}, 0, 11'd8);
    drain();
    send({8{8'h80}}, 0, 11'h400);
    send({8{8'h7F}}, 0, 11'h3F8);
    send({4{8'h80, 8'h7F}}, 0, 11'h7FC);
    drain();
    send({8{8'h07}}, 1, 11'd32);
    send({8{8'h07}}, 0, 11'd56);
    send({8{8'hFF}}, 1, 11'h7E0);
    drain();
    send(64'h00FF037F8019CE64, 0, 11'd76);
    send(64'h00FF037F8019CE64, 1, 11'd64);
    send({8{8'h9C}}, 0, 11'h4E0);
    send(64'h50463C32281E140A, 0, 11'd360);
    drain();
    chk_lat = 0;
    bus.out_ready = 0;
    nacc = 0;
    fork
      for (int k = 1; k <= 10; k++) send({8{8'(k)}}, 0, 11'(8 * k));
      begin
        repeat (5) @(negedge clk);
        s0 = bus.out_sum;
        c0 = bus.out_carry;
        a0 = bus.out_approx;
        @(negedge clk);
        chk("bp_accepted", W'(nacc), W'(LAT));
        chk("bp_in_ready", W'(bus.in_ready), 0);
        chk("bp_out_valid", W'(bus.out_valid), 1);
        chk("bp_hold_sum", bus.out_sum, s0);
        chk("bp_hold_carry", bus.out_carry, c0);
        chk("bp_hold_approx", W'(bus.out_approx), W'(a0));
        @(posedge clk);
        #1 bus.out_ready = 1;
      end
    join
    drain();
    bus.out_ready = 0;
    send({8{8'h02}}, 0, 11'd16);
    send({8{8'h03}}, 1, 11'd0);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("pre_rst_valid", W'(bus.out_valid), 1);
    #2 rst_n = 0;
    sb.delete();
    #1;
    chk("async_rst_valid", W'(bus.out_valid), 0);
    chk("async_rst_in_ready", W'(bus.in_ready), 1);
    bus.out_ready = 1;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", W'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1 chk_lat = 1;
    send({8{8'h05}}, 0, 11'd40);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
